// File: rtl/serial_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// serial_magnitude_comparator
//
// Compares two WIDTH-bit unsigned operands MSB-first, one 2-bit digit pair
// per clock, using an external combinational 2-bit comparator. The block
// presents the current digit pair on digit_a/digit_b. It consumes the
// comparator's greater/lesser/equal flags in the same cycle. The per-digit
// verdicts are reduced to one registered verdict for the whole operand.
//
// Parameters
//   WIDTH          operand width in bits; must be even and >= 2
//
// Configuration macro
//   EARLY_EXIT_EN  when defined, the scan stops on the first unequal digit.
//                  When undefined, every digit is always scanned, so latency
//                  is fixed and every digit is checked for protocol errors.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         begin a compare (accepted only when idle)
//   op_a, op_b    operands, sampled on the accepted start
//   digit_a/_b    current 2-bit digit pair to the external comparator
//   cmp_greater   comparator flag: digit_a >  digit_b
//   cmp_lesser    comparator flag: digit_a <  digit_b
//   cmp_equal     comparator flag: digit_a == digit_b
//   busy          high while digits are being scanned
//   done          one-cycle pulse; verdict valid from this cycle on
//   a_gt_b        registered verdict A >  B
//   a_lt_b        registered verdict A <  B
//   a_eq_b        registered verdict A == B
//   protocol_err  sticky: comparator flags were not one-hot during a scan
//
// Timing
//   A start accepted at edge 0 produces done after edge WIDTH/2+1. With
//   EARLY_EXIT_EN defined, done can instead follow edge k+1, where k is the
//   first unequal digit (1-based).
// ---------------------------------------------------------------------------
module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [1:0]       digit_a,
    output logic [1:0]       digit_b,
    input  logic             cmp_greater,
    input  logic             cmp_lesser,
    input  logic             cmp_equal,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic             protocol_err
);

    localparam int DIGITS = WIDTH / 2;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [CNT_W-1:0] digit_cnt;
    logic             decided;     // an unequal digit has been seen
    logic             decided_gt;  // direction of that first unequal digit

    // Decoded comparator return for the current digit.
    logic digit_gt;
    logic digit_lt;
    logic flags_bad;
    logic last_digit;
    logic exit_run;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        // Priority greater > lesser > equal. All flags zero falls through
        // to "equal", which leaves the running decision untouched.
        digit_gt   = cmp_greater;
        digit_lt   = !cmp_greater && cmp_lesser;
        flags_bad  = !(( cmp_greater && !cmp_lesser && !cmp_equal) ||
                       (!cmp_greater &&  cmp_lesser && !cmp_equal) ||
                       (!cmp_greater && !cmp_lesser &&  cmp_equal));
        last_digit = (digit_cnt == CNT_ONE);
        exit_run   = last_digit;
`ifdef EARLY_EXIT_EN
        // The first unequal digit settles the verdict, so stop scanning.
        if (!decided && (digit_gt || digit_lt)) begin
            exit_run = 1'b1;
        end
`else
        // Remaining digits are still scanned after a decision, so latency
        // stays fixed and every digit is checked for protocol errors.
`endif
    end

    assign busy    = (state == S_RUN);
    assign digit_a = (state == S_RUN) ? shift_a[WIDTH-1 -: 2] : 2'b00;
    assign digit_b = (state == S_RUN) ? shift_b[WIDTH-1 -: 2] : 2'b00;

    // NOTE: state registers use non-blocking assignments, so every register
    // in this block updates from values sampled before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand shift registers are reset along with the
            // control state, so a scan aborted by reset leaves no stale
            // operand data behind.
            state        <= S_IDLE;
            shift_a      <= '0;
            shift_b      <= '0;
            digit_cnt    <= '0;
            decided      <= 1'b0;
            decided_gt   <= 1'b0;
            done         <= 1'b0;
            a_gt_b       <= 1'b0;
            a_lt_b       <= 1'b0;
            a_eq_b       <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_RUN;
                        shift_a      <= op_a;
                        shift_b      <= op_b;
                        digit_cnt    <= CNT_LOAD;
                        decided      <= 1'b0;
                        decided_gt   <= 1'b0;
                        a_gt_b       <= 1'b0;
                        a_lt_b       <= 1'b0;
                        a_eq_b       <= 1'b0;
                        protocol_err <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (flags_bad) begin
                        protocol_err <= 1'b1;
                    end
                    // Only the first unequal digit counts. Later digits can
                    // never override it because the scan runs MSB-first.
                    if (!decided && (digit_gt || digit_lt)) begin
                        decided    <= 1'b1;
                        decided_gt <= digit_gt;
                    end
                    shift_a   <= shift_a << 2;
                    shift_b   <= shift_b << 2;
                    digit_cnt <= digit_cnt - CNT_ONE;
                    if (exit_run) begin
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    // Publish the verdict together with the done pulse.
                    // An undecided scan means every digit matched.
                    done   <= 1'b1;
                    a_gt_b <= decided && decided_gt;
                    a_lt_b <= decided && !decided_gt;
                    a_eq_b <= !decided;
                    state  <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// tb_serial_magnitude_comparator
//
// Directed bench for serial_magnitude_comparator with WIDTH = 8. The bench
// provides an ideal 2-bit comparator, which it can force to return invalid
// flag patterns. Expected values are hand-computed constants. Latencies are
// counted in rising edges after the edge that accepts start.
// ---------------------------------------------------------------------------
module tb_serial_magnitude_comparator;

    localparam int WIDTH = 8;

`ifdef EARLY_EXIT_EN
    localparam int LAT_80_7F   = 2;  // decided on digit 1
    localparam int BUSY_80_7F  = 1;
    localparam int LAT_FORCE   = 2;  // forced greater on digit 1
    localparam int LAT_ZERO    = 3;  // digit 1 forced "equal", digit 2 decides
    localparam int BUSY_ZERO   = 2;
`else
    localparam int LAT_80_7F   = 5;
    localparam int BUSY_80_7F  = 4;
    localparam int LAT_FORCE   = 5;
    localparam int LAT_ZERO    = 5;
    localparam int BUSY_ZERO   = 4;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic [1:0]       digit_a;
    logic [1:0]       digit_b;
    logic             cmp_greater;
    logic             cmp_lesser;
    logic             cmp_equal;
    logic             busy;
    logic             done;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             a_eq_b;
    logic             protocol_err;

    // 0: ideal comparator, 1: greater=lesser=1, 2: all flags zero
    int force_mode = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign cmp_greater = (force_mode == 1) ? 1'b1 :
                         (force_mode == 2) ? 1'b0 : (digit_a > digit_b);
    assign cmp_lesser  = (force_mode == 1) ? 1'b1 :
                         (force_mode == 2) ? 1'b0 : (digit_a < digit_b);
    assign cmp_equal   = (force_mode == 0) && (digit_a == digit_b);

    serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op_a         (op_a),
        .op_b         (op_b),
        .digit_a      (digit_a),
        .digit_b      (digit_b),
        .cmp_greater  (cmp_greater),
        .cmp_lesser   (cmp_lesser),
        .cmp_equal    (cmp_equal),
        .busy         (busy),
        .done         (done),
        .a_gt_b       (a_gt_b),
        .a_lt_b       (a_lt_b),
        .a_eq_b       (a_eq_b),
        .protocol_err (protocol_err)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Starts one compare and waits (bounded) for done.
    //   mode 0: plain run
    //   mode 1: start held high with A=0x00,B=0xFF during RUN cycle 1
    //   mode 2: comparator forced greater=lesser=1 on digit 1
    //   mode 3: comparator forced all-zero on digit 1
    // lat = rising edges after the accepting edge until done is seen
    // (-1 on timeout). busy_cnt = cycles observed with busy high.
    task automatic run_cmp(input logic [7:0] a, input logic [7:0] b,
                           input int mode, output int lat, output int busy_cnt,
                           output logic [1:0] da0, output logic [1:0] db0,
                           output logic perr0);
        @(negedge clk);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(posedge clk);                // edge 0
        @(negedge clk);
        start    = 1'b0;
        da0      = digit_a;
        db0      = digit_b;
        perr0    = protocol_err;
        busy_cnt = busy ? 1 : 0;
        lat      = -1;
        if (mode == 1) begin
            start = 1'b1;
            op_a  = 8'h00;
            op_b  = 8'hFF;
        end
        if (mode == 2) force_mode = 1;
        if (mode == 3) force_mode = 2;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            start      = 1'b0;
            force_mode = 0;
            if (busy) busy_cnt++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int         lat;
        int         bcnt;
        int         done_seen;
        logic [1:0] da0;
        logic [1:0] db0;
        logic       perr0;

        // ---------------- reset state ----------------
        #12;
        check("rst_busy",    32'(busy),         32'd0);
        check("rst_done",    32'(done),         32'd0);
        check("rst_verdict", {29'd0, a_gt_b, a_lt_b, a_eq_b}, 32'd0);
        check("rst_perr",    32'(protocol_err), 32'd0);
        check("rst_digits",  {28'd0, digit_a, digit_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- equal operands ----------------
        run_cmp(8'hB4, 8'hB4, 0, lat, bcnt, da0, db0, perr0);
        check("eq_first_digit_a", 32'(da0), 32'd2);
        check("eq_first_digit_b", 32'(db0), 32'd2);
        check("eq_latency",  32'(lat),  32'd5);
        check("eq_busy_cyc", 32'(bcnt), 32'd4);
        check("eq_verdict",  {29'd0, a_gt_b, a_lt_b, a_eq_b}, 32'b001);
        check("eq_perr",     32'(protocol_err), 32'd0);
        @(negedge clk);
        check("eq_done_one_cycle", 32'(done), 32'd0);
        check("eq_verdict_held", {29'd0, a_gt_b, a_lt_b, a_eq_b}, 32'b001);
        check("eq_idle_digits", {28'd0, digit_a, digit_b}, 32'd0);

        // ---------------- greater on first digit ----------------
        run_cmp(8'h80, 8'h7F, 0, lat, bcnt, da0, db0, perr0);
        check("gt_latency",  32'(lat),  32'(LAT_80_7F));
        check("gt_busy_cyc", 32'(bcnt), 32'(BUSY_80_7F));
        check("gt_verdict",  {29'd0, a_gt_b, a_lt_b, a_eq_b}, 32'b100);

        // ---------------- lesser on last digit ----------------
        run_cmp(8'h12, 8'h13, 0, lat, bcnt, da0, db0, perr0);
        check("lt_latency", 32'(lat), 32'd5);
        check("lt_verdict", {29'd0, a_gt_b, a_lt_b, a_eq_b}, 32'b010);

        // ---------------- start during RUN is ignored ----------------
        run_cmp(8'h13, 8'h12, 1, lat, bcnt, da0, db0, perr0);
        check("ign_latency", 32'(lat), 32'd5);
        check("ign_verdict", {29'd0, a_gt_b, a_lt_b, a_eq_b}, 32'b100);
        @(negedge clk);
        check("ign_no_restart", 32'(busy), 32'd0);

        // ---------------- reset in RUN cycle 2 ----------------
        @(negedge clk);
        start = 1'b1;
        op_a  = 8'h12;
        op_b  = 8'h13;
        @(posedge clk);                // edge 0
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);                // edge 1: digit 2 now presented
        @(negedge clk);
        check("abort_pre_digit_a", 32'(digit_a), 32'd1);
        check("abort_pre_busy",    32'(busy),    32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy",    32'(busy), 32'd0);
        check("abort_done",    32'(done), 32'd0);
        check("abort_verdict", {29'd0, a_gt_b, a_lt_b, a_eq_b}, 32'd0);
        check("abort_digits",  {28'd0, digit_a, digit_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);

        // ---------------- protocol error: greater=lesser=1 ----------------
        run_cmp(8'h12, 8'h13, 2, lat, bcnt, da0, db0, perr0);
        check("perr_latency", 32'(lat), 32'(LAT_FORCE));
        check("perr_flag",    32'(protocol_err), 32'd1);
        check("perr_verdict", {29'd0, a_gt_b, a_lt_b, a_eq_b}, 32'b100);

        // ---------------- next start clears protocol_err ----------------
        run_cmp(8'hB4, 8'hB4, 0, lat, bcnt, da0, db0, perr0);
        check("perr_cleared_at_start", 32'(perr0), 32'd0);
        check("perr_cleared_end",      32'(protocol_err), 32'd0);
        check("perr_next_verdict", {29'd0, a_gt_b, a_lt_b, a_eq_b}, 32'b001);

        // ---------------- protocol error: all flags zero ----------------
        run_cmp(8'h80, 8'h7F, 3, lat, bcnt, da0, db0, perr0);
        check("zero_latency",  32'(lat),  32'(LAT_ZERO));
        check("zero_busy_cyc", 32'(bcnt), 32'(BUSY_ZERO));
        check("zero_flag",     32'(protocol_err), 32'd1);
        check("zero_verdict",  {29'd0, a_gt_b, a_lt_b, a_eq_b}, 32'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
